// File: rtl/socket_mem_arb.sv
// rtl/socket_mem_arb.sv - round-robin merge of socket memory buses onto one L2 bus
// Requests gain the socket index in the upper tag bits; responses are steered back by it.
module socket_mem_arb #(
  parameter int NUM_INPUTS  = 4,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_SIZE   = 64,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16,
  localparam int DW  = 8 * DATA_SIZE,
  localparam int LG  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0,
  localparam int OTW = TAG_WIDTH + LG
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_INPUTS-1:0]           in_req_valid,
  input  logic [NUM_INPUTS-1:0]           in_req_rw,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0] in_req_addr,
  input  logic [NUM_INPUTS*DW-1:0]        in_req_data,
  input  logic [NUM_INPUTS*DATA_SIZE-1:0] in_req_byteen,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0] in_req_tag,
  output logic [NUM_INPUTS-1:0]           in_req_ready,
  output logic [NUM_INPUTS-1:0]           in_rsp_valid,
  output logic [NUM_INPUTS*DW-1:0]        in_rsp_data,
  output logic [NUM_INPUTS*TAG_WIDTH-1:0] in_rsp_tag,
  input  logic [NUM_INPUTS-1:0]           in_rsp_ready,
  output logic                            out_req_valid,
  output logic                            out_req_rw,
  output logic [ADDR_WIDTH-1:0]           out_req_addr,
  output logic [DW-1:0]                   out_req_data,
  output logic [DATA_SIZE-1:0]            out_req_byteen,
  output logic [OTW-1:0]                  out_req_tag,
  input  logic                            out_req_ready,
  input  logic                            out_rsp_valid,
  input  logic [DW-1:0]                   out_rsp_data,
  input  logic [OTW-1:0]                  out_rsp_tag,
  output logic                            out_rsp_ready,
  output logic                            busy
);

  localparam int IW = (LG > 0) ? LG : 1;
  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam int EW = 1 + ADDR_WIDTH + DW + DATA_SIZE + OTW;

  logic [CW-1:0]         cnt_q [NUM_INPUTS];
  logic [CW-1:0]         cnt_d [NUM_INPUTS];
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [EW-1:0]         buf_q [2];
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [1:0]            count_q, count_d;
  logic                  valid_q, busy_q, busy_d;

  logic [NUM_INPUTS-1:0] eligible, inc_v, dec_v;
  logic                  grant_found;
  logic [IW-1:0]         grant_idx;
  logic                  room, push, pop;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [OTW-1:0]        push_tag;
  logic [EW-1:0]         push_data;
  logic [IW-1:0]         rsp_idx;
  logic                  rsp_idx_ok, rsp_fire;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_INPUTS) s = s - NUM_INPUTS;
    return IW'(s);
  endfunction

  // Reads stall at the outstanding limit; writes never consume a slot.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      eligible[i] = in_req_valid[i] && (in_req_rw[i] || (cnt_q[i] != CW'(MAX_PENDING)));
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!grant_found && eligible[wrap_add(ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // Room is taken from the registered occupancy only, so a full buffer never accepts.
  assign room = (count_q != 2'd2);
  assign push = room && grant_found;
  assign pop  = valid_q && out_req_ready;

  always_comb begin
    in_req_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      in_req_ready[i] = reset && push && (grant_idx == IW'(i));
  end

  assign sel_tag = in_req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH];

  generate
    if (LG > 0) begin : g_idx
      assign push_tag = {grant_idx, sel_tag};
      assign rsp_idx  = out_rsp_tag[OTW-1:TAG_WIDTH];
    end else begin : g_noidx
      assign push_tag = sel_tag;
      assign rsp_idx  = '0;
    end
  endgenerate

  assign push_data = {in_req_rw[grant_idx],
                      in_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH],
                      in_req_data[grant_idx*DW +: DW],
                      in_req_byteen[grant_idx*DATA_SIZE +: DATA_SIZE],
                      push_tag};

  always_comb begin
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ptr_d   = ptr_q;
    if (push) begin
      wr_d  = ~wr_q;
      ptr_d = wrap_add(grant_idx, 1);
    end
    if (pop) rd_d = ~rd_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  assign {out_req_rw, out_req_addr, out_req_data, out_req_byteen, out_req_tag} = buf_q[rd_q];
  assign out_req_valid = valid_q;
  assign busy          = busy_q;

  // Out-of-range indices (non power-of-two counts) are swallowed without touching counters.
  assign rsp_idx_ok    = (int'(rsp_idx) < NUM_INPUTS);
  assign out_rsp_ready = rsp_idx_ok ? in_rsp_ready[rsp_idx] : 1'b1;
  assign rsp_fire      = out_rsp_valid && out_rsp_ready && rsp_idx_ok;
  assign in_rsp_data   = {NUM_INPUTS{out_rsp_data}};
  assign in_rsp_tag    = {NUM_INPUTS{out_rsp_tag[TAG_WIDTH-1:0]}};

  always_comb begin
    in_rsp_valid = '0;
    inc_v        = '0;
    dec_v        = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_rsp_valid[i] = out_rsp_valid && rsp_idx_ok && (rsp_idx == IW'(i));
      inc_v[i]        = in_req_ready[i] && !in_req_rw[i];
      dec_v[i]        = rsp_fire && (rsp_idx == IW'(i));
    end
  end

  always_comb begin
    busy_d = (count_d != 2'd0);
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i])
        cnt_d[i] = cnt_q[i] + 1'b1;
      else if (dec_v[i] && !inc_v[i] && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - 1'b1;
      busy_d = busy_d | (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      count_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      valid_q <= (count_d != 2'd0);
      busy_q  <= busy_d;
      for (int i = 0; i < NUM_INPUTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Payload storage needs no reset; occupancy gates everything that reads it.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_q] <= push_data;
  end

endmodule

// File: tb/tb_socket_mem_arb.sv
// tb/tb_socket_mem_arb.sv - self-checking bench for socket_mem_arb
// A queue/array reference model is compared every falling edge; directed literals pin it.
module tb_socket_mem_arb;
  localparam int N = 4, AW = 26, DS = 4, DW = 32, TW = 8, MP = 2, OTW = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    in_req_valid, in_req_rw, in_req_ready, in_rsp_valid, in_rsp_ready;
  logic [N*AW-1:0] in_req_addr;
  logic [N*DW-1:0] in_req_data, in_rsp_data;
  logic [N*DS-1:0] in_req_byteen;
  logic [N*TW-1:0] in_req_tag, in_rsp_tag;
  logic            out_req_valid, out_req_rw, out_req_ready, out_rsp_valid, out_rsp_ready, busy;
  logic [AW-1:0]   out_req_addr;
  logic [DW-1:0]   out_req_data, out_rsp_data;
  logic [DS-1:0]   out_req_byteen;
  logic [OTW-1:0]  out_req_tag, out_rsp_tag;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  socket_mem_arb #(.NUM_INPUTS(N), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW),
                   .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
    .in_req_data(in_req_data), .in_req_byteen(in_req_byteen), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready), .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data),
    .in_rsp_tag(in_rsp_tag), .in_rsp_ready(in_rsp_ready),
    .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
    .out_req_data(out_req_data), .out_req_byteen(out_req_byteen), .out_req_tag(out_req_tag),
    .out_req_ready(out_req_ready), .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data),
    .out_rsp_tag(out_rsp_tag), .out_rsp_ready(out_rsp_ready), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DS-1:0] be;
    logic [OTW-1:0] tag;
  } req_t;

  req_t          mq[$];
  int            mcnt[N];
  int            mptr;
  logic [AW-1:0] seen_q[$];
  int            g_m, idx_m;
  logic          room_m, busy_m;
  logic [N-1:0]  rdy_m, rv_m;
  req_t          r_m;

  // Inputs are stable from here to the next rising edge, so the model also advances here.
  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      mptr = 0;
      chk("rst_out_valid", out_req_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_req_ready, 0);
    end else begin
      room_m = (mq.size() < 2);
      g_m = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mptr + k) % N;
        if (g_m < 0 && in_req_valid[i] && !(!in_req_rw[i] && mcnt[i] >= MP)) g_m = i;
      end
      rdy_m = '0;
      if (room_m && g_m >= 0) rdy_m[g_m] = 1'b1;
      chk("in_req_ready", in_req_ready, rdy_m);
      chk("out_req_valid", out_req_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("out_req_tag", out_req_tag, mq[0].tag);
        chk("out_req_addr", out_req_addr, mq[0].addr);
        chk("out_req_data", out_req_data, mq[0].data);
        chk("out_req_rw", out_req_rw, mq[0].rw);
        chk("out_req_byteen", out_req_byteen, mq[0].be);
      end
      busy_m = (mq.size() > 0);
      for (int i = 0; i < N; i++) if (mcnt[i] != 0) busy_m = 1'b1;
      chk("busy", busy, busy_m);
      idx_m = int'(out_rsp_tag[OTW-1:TW]);
      rv_m = '0;
      if (out_rsp_valid) rv_m[idx_m] = 1'b1;
      chk("in_rsp_valid", in_rsp_valid, rv_m);
      chk("out_rsp_ready", out_rsp_ready, in_rsp_ready[idx_m]);
      chk("in_rsp_tag3", in_rsp_tag[3*TW +: TW], out_rsp_tag[TW-1:0]);
      chk("in_rsp_data0", in_rsp_data[DW-1:0], out_rsp_data);

      if (mq.size() > 0 && out_req_ready) begin
        seen_q.push_back(out_req_addr);
        void'(mq.pop_front());
      end
      if (room_m && g_m >= 0) begin
        r_m.rw   = in_req_rw[g_m];
        r_m.addr = in_req_addr[g_m*AW +: AW];
        r_m.data = in_req_data[g_m*DW +: DW];
        r_m.be   = in_req_byteen[g_m*DS +: DS];
        r_m.tag  = {2'(g_m), in_req_tag[g_m*TW +: TW]};
        mq.push_back(r_m);
        if (!r_m.rw) mcnt[g_m]++;
        mptr = (g_m + 1) % N;
      end
      if (out_rsp_valid && in_rsp_ready[idx_m] && mcnt[idx_m] > 0) mcnt[idx_m]--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] t);
    in_req_valid[i]            = 1'b1;
    in_req_rw[i]               = rw;
    in_req_addr[i*AW +: AW]    = a;
    in_req_data[i*DW +: DW]    = {6'(i), a};
    in_req_byteen[i*DS +: DS]  = 4'hF ^ 4'(i);
    in_req_tag[i*TW +: TW]     = t;
  endtask

  logic [AW-1:0] a;
  logic          rdy;
  int            acc;

  initial begin
    in_req_valid = '1; in_req_rw = '0; in_req_addr = '0; in_req_data = '0;
    in_req_byteen = '0; in_req_tag = '0; in_rsp_ready = '1;
    out_req_ready = 1'b1; out_rsp_valid = 1'b0; out_rsp_data = '0; out_rsp_tag = '0;
    #3;
    chk("reset_in_ready", in_req_ready, 0);
    chk("reset_out_valid", out_req_valid, 0);
    chk("reset_busy", busy, 0);
    in_req_valid = '0;
    tick(); tick();
    reset = 1'b1;

    // fairness: four readers, grants rotate 0..3 twice at one per cycle
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(26'h10 + i), TW'(8'h10 + i));
    tick();
    for (int c = 0; c < 8; c++) begin
      chk("fair_valid", out_req_valid, 1);
      chk("fair_order", out_req_tag[OTW-1:TW], c % 4);
      tick();
    end
    #1 chk("fair_all_blocked", in_req_ready, 0);
    in_req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      out_rsp_valid = 1'b1;
      out_rsp_tag   = {2'(k % 4), 8'(k)};
      out_rsp_data  = 32'hD000 + k;
      tick();
    end
    out_rsp_valid = 1'b0;
    #1 chk("fair_drained_busy", busy, 0);

    // single request from input 2
    set_req(2, 1'b0, 26'h100, 8'h5A);
    #1 chk("single_ready", in_req_ready, 4'b0100);
    tick();
    in_req_valid = '0;
    chk("single_valid", out_req_valid, 1);
    chk("single_tag", out_req_tag, 10'h25A);
    chk("single_addr", out_req_addr, 26'h100);
    chk("single_busy", busy, 1);
    chk("single_cnt", dut.cnt_q[2], 1);
    tick();
    out_rsp_valid = 1'b1; out_rsp_tag = 10'h25A; out_rsp_data = 32'h1234_5678;
    #1 chk("single_rsp_valid", in_rsp_valid, 4'b0100);
    tick();
    out_rsp_valid = 1'b0;
    #1 chk("single_idle", busy, 0);

    // backpressure: input 0 streams writes into a stalled output
    seen_q.delete();
    out_req_ready = 1'b0;
    a = 26'h200; acc = 0;
    set_req(0, 1'b1, a, 8'h33);
    for (int c = 0; c < 5; c++) begin
      #1 rdy = in_req_ready[0];
      chk("bp_ready", rdy, c < 2);
      if (c >= 1) chk("bp_hold", out_req_addr, 26'h200);
      tick();
      if (rdy) begin acc++; a = a + 1'b1; set_req(0, 1'b1, a, 8'h33); end
    end
    chk("bp_two_buffered", acc, 2);
    out_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 rdy = in_req_ready[0];
      tick();
      if (rdy) begin acc++; a = a + 1'b1; set_req(0, 1'b1, a, 8'h33); end
    end
    in_req_valid = '0;
    tick(); tick(); tick();
    chk("bp_count", seen_q.size(), acc);
    for (int k = 0; k < seen_q.size(); k++) chk("bp_order", seen_q[k], AW'(26'h200 + k));

    // pending limit on input 1
    set_req(1, 1'b0, 26'h300, 8'hA0);
    #1 chk("pl_r1", in_req_ready[1], 1);
    tick();
    set_req(1, 1'b0, 26'h301, 8'hA1);
    #1 chk("pl_r2", in_req_ready[1], 1);
    tick();
    set_req(1, 1'b0, 26'h302, 8'hA2);
    #1 chk("pl_r3_stall", in_req_ready[1], 0);
    tick();
    in_req_rw[1] = 1'b1;
    #1 chk("pl_write_pass", in_req_ready[1], 1);
    tick();
    in_req_rw[1] = 1'b0;
    #1 chk("pl_still_blocked", in_req_ready[1], 0);
    out_rsp_valid = 1'b1; out_rsp_tag = 10'h1A5;
    #1 chk("pl_rsp_valid", in_rsp_valid, 4'b0010);
    tick();
    out_rsp_valid = 1'b0;
    #1 chk("pl_unblock", in_req_ready[1], 1);
    tick();
    in_req_valid = '0;

    // response demux with a stalled consumer
    set_req(3, 1'b0, 26'h3C0, 8'hC7);
    tick();
    in_req_valid = '0;
    in_rsp_ready = 4'b0111; out_rsp_valid = 1'b1; out_rsp_tag = 10'h3C7; out_rsp_data = 32'hCAFE_0003;
    #1 chk("dm_valid", in_rsp_valid, 4'b1000);
    chk("dm_ready_low", out_rsp_ready, 0);
    chk("dm_tag", in_rsp_tag[3*TW +: TW], 8'hC7);
    tick();
    chk("dm_cnt_hold", dut.cnt_q[3], 1);
    in_rsp_ready = 4'b1111;
    #1 chk("dm_ready_high", out_rsp_ready, 1);
    tick();
    out_rsp_valid = 1'b0;
    chk("dm_cnt_dec", dut.cnt_q[3], 0);

    // asynchronous reset with a full buffer and live counters
    out_req_ready = 1'b0;
    set_req(0, 1'b1, 26'h400, 8'h44);
    tick();
    set_req(0, 1'b1, 26'h401, 8'h45);
    tick();
    in_req_valid = '0;
    set_req(2, 1'b0, 26'h402, 8'h46);
    #1 chk("rm_pre_valid", out_req_valid, 1);
    chk("rm_pre_busy", busy, 1);
    chk("rm_pre_cnt", dut.cnt_q[1], 2);
    reset = 1'b0;
    #1 chk("rm_valid", out_req_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_ready", in_req_ready, 0);
    chk("rm_cnt", dut.cnt_q[1], 0);
    tick(); tick();
    reset = 1'b1;
    out_req_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(26'h500 + i), TW'(8'h50 + i));
    #1 chk("rm_first_grant", in_req_ready, 4'b0001);
    tick();
    in_req_valid = '0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
